// File: rtl/adc_cap_pkg.sv
// Shared types and helpers for the ADC capture writer.
// The sample RAM holds 2**PTR_BITS entries; samples are two's complement.
package adc_cap_pkg;

  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_PTR_BITS     = 11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } cap_state_t;

  // Signed a < b from the two sign bits and the unsigned a < b result.
  // This keeps the helper independent of the sample width.
  function automatic logic signed_lt(input logic a_msb, input logic b_msb,
                                     input logic a_ult_b);
    return (a_msb != b_msb) ? a_msb : a_ult_b;
  endfunction

endpackage

// File: rtl/adc_trig_detect.sv
// Trigger detector: rising level crossing on consecutive samples plus a
// pending software trigger; hit is combinational and aligned with s_valid.
module adc_trig_detect
  import adc_cap_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    clr,
  input  logic                    track,
  input  logic                    armed,
  input  logic                    s_valid,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  input  logic                    sw_trig,
  input  logic                    trig_en,
  input  logic [SAMPLE_WIDTH-1:0] trig_level,
  output logic                    hit
);

  logic [SAMPLE_WIDTH-1:0] prev;
  logic                    prev_valid;
  logic                    sw_pend;
  logic                    prev_below;
  logic                    cur_at_or_above;
  logic                    level_hit;

  assign prev_below      = signed_lt(prev[SAMPLE_WIDTH-1], trig_level[SAMPLE_WIDTH-1],
                                     prev < trig_level);
  assign cur_at_or_above = !signed_lt(s_data[SAMPLE_WIDTH-1], trig_level[SAMPLE_WIDTH-1],
                                      s_data < trig_level);
  assign level_hit       = trig_en & prev_valid & prev_below & cur_at_or_above;
  assign hit             = armed & s_valid & (level_hit | sw_trig | sw_pend);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      sw_pend    <= 1'b0;
    end else if (clr) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      sw_pend    <= 1'b0;
    end else begin
      if (track && s_valid) begin
        prev       <= s_data;
        prev_valid <= 1'b1;
      end
      // A software trigger is only remembered while waiting for the trigger.
      if (!armed || hit)
        sw_pend <= 1'b0;
      else if (sw_trig)
        sw_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture writer for the circular ADC sample RAM: arm, pre-trigger fill,
// trigger wait, post-trigger capture, then freeze and publish the window.
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int PTR_BITS     = DEF_PTR_BITS
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    s_valid,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    sw_trig,
  input  logic                    trig_en,
  input  logic [SAMPLE_WIDTH-1:0] trig_level,
  input  logic [PTR_BITS-1:0]     pre_count,
  input  logic [PTR_BITS-1:0]     post_count,
  output logic                    ram_we,
  output logic [PTR_BITS-1:0]     ram_waddr,
  output logic [SAMPLE_WIDTH-1:0] ram_wdata,
  output logic                    busy,
  output logic                    done,
  output logic [PTR_BITS-1:0]     trig_addr,
  output logic [PTR_BITS-1:0]     start_addr,
  output logic                    overwrite
);

  // state | meaning
  // IDLE  | not capturing, writes suppressed
  // PRE   | filling pre-trigger history, triggers ignored
  // WAIT  | writing and watching for a trigger
  // POST  | writing post-trigger samples
  // DONE  | buffer frozen, addresses published

  localparam logic [PTR_BITS+1:0] DEPTH_W = {2'b01, {PTR_BITS{1'b0}}};

  cap_state_t          state, state_nxt;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] fill_cnt;
  logic [PTR_BITS-1:0] post_cnt;
  logic [PTR_BITS-1:0] pre_lat;
  logic [PTR_BITS-1:0] post_lat;
  logic [PTR_BITS-1:0] trig_src;
  logic [PTR_BITS-1:0] start_nxt;
  logic [PTR_BITS+1:0] win_len;
  logic                active;
  logic                wr_en;
  logic                arm_acc;
  logic                trig_hit;
  logic                ovf_calc;

  assign active   = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
  assign wr_en    = active && s_valid;
  assign arm_acc  = arm && !abort && ((state == ST_IDLE) || (state == ST_DONE));
  assign win_len  = {2'b00, pre_count} + {2'b00, post_count} + {{(PTR_BITS+1){1'b0}}, 1'b1};
  assign ovf_calc = win_len > DEPTH_W;

  adc_trig_detect #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_trig (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .clr       (abort | arm_acc),
    .track     (active),
    .armed     (state == ST_WAIT),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .sw_trig   (sw_trig),
    .trig_en   (trig_en),
    .trig_level(trig_level),
    .hit       (trig_hit)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    // With post_count=0 the trigger write itself completes the window, so
    // the trigger address is still on wr_ptr rather than in trig_addr.
    trig_src  = (state == ST_WAIT) ? wr_ptr : trig_addr;
    start_nxt = overwrite ? (trig_src + post_lat + PTR_BITS'(1)) : (trig_src - pre_lat);
    if (abort) begin
      state_nxt = ST_IDLE;
    end else if (arm_acc) begin
      state_nxt = (pre_count == '0) ? ST_WAIT : ST_PRE;
    end else begin
      case (state)
        ST_PRE:  if (wr_en && (fill_cnt + PTR_BITS'(1) == pre_lat)) state_nxt = ST_WAIT;
        ST_WAIT: if (trig_hit) state_nxt = (post_lat == '0) ? ST_DONE : ST_POST;
        ST_POST: if (wr_en && (post_cnt == PTR_BITS'(1))) state_nxt = ST_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ram_we     <= 1'b0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
      overwrite  <= 1'b0;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      pre_lat    <= '0;
      post_lat   <= '0;
    end else begin
      ram_we <= wr_en;
      if (wr_en) begin
        ram_waddr <= wr_ptr;
        ram_wdata <= s_data;
      end
      busy <= (state_nxt == ST_PRE) || (state_nxt == ST_WAIT) || (state_nxt == ST_POST);

      if (arm_acc)
        wr_ptr <= '0;
      else if (wr_en)
        wr_ptr <= wr_ptr + PTR_BITS'(1);

      if (arm_acc) begin
        pre_lat   <= pre_count;
        post_lat  <= post_count;
        overwrite <= ovf_calc;
        fill_cnt  <= '0;
        post_cnt  <= '0;
      end else if (!abort) begin
        if (state == ST_PRE && wr_en)
          fill_cnt <= fill_cnt + PTR_BITS'(1);
        if (state == ST_WAIT && trig_hit) begin
          trig_addr <= wr_ptr;
          post_cnt  <= post_lat;
        end
        if (state == ST_POST && wr_en)
          post_cnt <= post_cnt - PTR_BITS'(1);
      end

      if (abort || arm_acc) begin
        done <= 1'b0;
      end else if (state != ST_DONE && state_nxt == ST_DONE) begin
        done       <= 1'b1;
        start_addr <= start_nxt;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl on a 16-entry RAM.
module tb_adc_capture_ctrl;

  localparam int SW = 16;
  localparam int PB = 4;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          s_valid;
  logic [SW-1:0] s_data;
  logic          arm;
  logic          abort;
  logic          sw_trig;
  logic          trig_en;
  logic [SW-1:0] trig_level;
  logic [PB-1:0] pre_count;
  logic [PB-1:0] post_count;
  logic          ram_we;
  logic [PB-1:0] ram_waddr;
  logic [SW-1:0] ram_wdata;
  logic          busy;
  logic          done;
  logic [PB-1:0] trig_addr;
  logic [PB-1:0] start_addr;
  logic          overwrite;

  adc_capture_ctrl #(
    .SAMPLE_WIDTH(SW),
    .PTR_BITS    (PB)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .arm       (arm),
    .abort     (abort),
    .sw_trig   (sw_trig),
    .trig_en   (trig_en),
    .trig_level(trig_level),
    .pre_count (pre_count),
    .post_count(post_count),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr),
    .start_addr(start_addr),
    .overwrite (overwrite)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {
    logic [PB-1:0] addr;
    logic [SW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           exp_wr;
  int            n_chk  = 0;
  int            n_pass = 0;
  logic [PB-1:0] ep;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && ram_we) begin
      if (exp_q.size() == 0) begin
        chk_val("unexpected_write", 32'(ram_we), 32'd0);
      end else begin
        exp_wr = exp_q.pop_front();
        chk_val("waddr", 32'(ram_waddr), 32'(exp_wr.addr));
        chk_val("wdata", 32'(ram_wdata), 32'(exp_wr.data));
      end
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_arm(input logic [PB-1:0] pre, input logic [PB-1:0] post);
    pre_count  = pre;
    post_count = post;
    arm        = 1'b1;
    tick();
    arm = 1'b0;
    ep  = '0;
  endtask

  task automatic send(input logic [SW-1:0] d, input logic sw, input logic wr);
    s_valid = 1'b1;
    s_data  = d;
    sw_trig = sw;
    if (wr) begin
      exp_q.push_back({ep, d});
      ep = ep + PB'(1);
    end
    tick();
    s_valid = 1'b0;
    sw_trig = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wb_rst_i   = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    arm        = 1'b0;
    abort      = 1'b0;
    sw_trig    = 1'b0;
    trig_en    = 1'b0;
    trig_level = '0;
    pre_count  = '0;
    post_count = '0;
    ep         = '0;
    tick();
    tick();
    chk_val("rst_ram_we", 32'(ram_we), 32'd0);
    chk_val("rst_waddr", 32'(ram_waddr), 32'd0);
    chk_val("rst_wdata", 32'(ram_wdata), 32'd0);
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_done", 32'(done), 32'd0);
    chk_val("rst_trig_addr", 32'(trig_addr), 32'd0);
    chk_val("rst_start_addr", 32'(start_addr), 32'd0);
    chk_val("rst_overwrite", 32'(overwrite), 32'd0);
    wb_rst_i = 1'b0;
    tick();

    // Reset asserted while in POST
    do_arm(4'd0, 4'd5);
    chk_val("midpost_busy_armed", 32'(busy), 32'd1);
    send(16'h1234, 1'b1, 1'b1);
    chk_val("midpost_busy_post", 32'(busy), 32'd1);
    s_valid = 1'b1;
    s_data  = 16'h5678;
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b1;
    #1;
    chk_val("midpost_async_we", 32'(ram_we), 32'd0);
    chk_val("midpost_async_busy", 32'(busy), 32'd0);
    chk_val("midpost_async_waddr", 32'(ram_waddr), 32'd0);
    tick();
    chk_val("midpost_held_we", 32'(ram_we), 32'd0);
    s_valid  = 1'b0;
    wb_rst_i = 1'b0;
    tick();

    // Software trigger on a ramp
    trig_en = 1'b0;
    do_arm(4'd4, 4'd3);
    chk_val("sw_busy", 32'(busy), 32'd1);
    chk_val("sw_overwrite", 32'(overwrite), 32'd0);
    for (int i = 0; i < 14; i++) begin
      send(SW'(i), (i == 10), 1'b1);
      if (i == 12) chk_val("sw_done_early", 32'(done), 32'd0);
    end
    chk_val("sw_done", 32'(done), 32'd1);
    chk_val("sw_busy_done", 32'(busy), 32'd0);
    chk_val("sw_trig_addr", 32'(trig_addr), 32'd10);
    chk_val("sw_start_addr", 32'(start_addr), 32'd6);
    send(16'd14, 1'b0, 1'b0);

    // Level trigger with a signed threshold, armed from DONE
    trig_en    = 1'b1;
    trig_level = 16'h0000;
    do_arm(4'd2, 4'd2);
    chk_val("lvl_done_cleared", 32'(done), 32'd0);
    send(16'hFFF0, 1'b0, 1'b1);
    send(16'hFFF8, 1'b0, 1'b1);
    send(16'h0005, 1'b0, 1'b1);
    send(16'h0010, 1'b0, 1'b1);
    chk_val("lvl_done_early", 32'(done), 32'd0);
    send(16'h0020, 1'b0, 1'b1);
    chk_val("lvl_done", 32'(done), 32'd1);
    chk_val("lvl_trig_addr", 32'(trig_addr), 32'd2);
    chk_val("lvl_start_addr", 32'(start_addr), 32'd0);

    // Wrap and overwrite
    trig_en = 1'b0;
    do_arm(4'd10, 4'd10);
    chk_val("wrap_overwrite", 32'(overwrite), 32'd1);
    for (int i = 0; i < 23; i++)
      send(SW'(100 + i), (i == 12), 1'b1);
    chk_val("wrap_done", 32'(done), 32'd1);
    chk_val("wrap_trig_addr", 32'(trig_addr), 32'd12);
    chk_val("wrap_start_addr", 32'(start_addr), 32'd7);

    // Abort and arm together in WAIT
    do_arm(4'd1, 4'd1);
    chk_val("ab_overwrite", 32'(overwrite), 32'd0);
    send(16'h0011, 1'b0, 1'b1);
    chk_val("ab_busy_wait", 32'(busy), 32'd1);
    pre_count = 4'd2;
    abort     = 1'b1;
    arm       = 1'b1;
    tick();
    abort = 1'b0;
    arm   = 1'b0;
    chk_val("ab_busy", 32'(busy), 32'd0);
    chk_val("ab_done", 32'(done), 32'd0);
    send(16'h0022, 1'b1, 1'b0);
    do_arm(4'd0, 4'd0);
    chk_val("ab_rearm_busy", 32'(busy), 32'd1);
    send(16'h0033, 1'b1, 1'b1);
    chk_val("ab_rearm_done", 32'(done), 32'd1);
    chk_val("ab_rearm_trig_addr", 32'(trig_addr), 32'd0);
    chk_val("ab_rearm_start_addr", 32'(start_addr), 32'd0);

    // Triggers during PRE are ignored
    trig_en    = 1'b1;
    trig_level = 16'h0000;
    do_arm(4'd3, 4'd1);
    send(16'hFFFB, 1'b0, 1'b1);
    send(16'h0005, 1'b1, 1'b1);
    send(16'hFFFD, 1'b0, 1'b1);
    send(16'hFFFE, 1'b0, 1'b1);
    chk_val("pre_no_trig_busy", 32'(busy), 32'd1);
    send(16'h0007, 1'b0, 1'b1);
    chk_val("pre_post_done", 32'(done), 32'd0);
    send(16'h0009, 1'b0, 1'b1);
    chk_val("pre_done", 32'(done), 32'd1);
    chk_val("pre_trig_addr", 32'(trig_addr), 32'd4);
    chk_val("pre_start_addr", 32'(start_addr), 32'd1);

    tick();
    tick();
    chk_val("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
